// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and result bundle between the front end, the sequencer and the ALU.
// The front end (master) drives requests and supplies the combinational ALU result; the sequencer (slave) drives the ALU inputs and status.
interface alu_op_sequencer_if;
  logic       start;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] alu_key;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [7:0] alu_out;
  logic [7:0] result;
  logic       busy;
  logic       done;

  modport master (
    output start, op, a, b, alu_out,
    input  alu_key, alu_a, alu_b, result, busy, done
  );

  modport slave (
    input  start, op, a, b, alu_out,
    output alu_key, alu_a, alu_b, result, busy, done
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time (result after 2 cycles) or a 4x4 shift-add multiply (after 5 cycles).
// start is sampled only in IDLE; requests arriving while busy are dropped, not queued.
module alu_op_sequencer (
  input  logic              clk,
  input  logic              reset,
  alu_op_sequencer_if.slave bus
);

  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] KEY_ADD = 3'b110;
  localparam logic [2:0] KEY_NOP = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [2:0] op_r;
  logic [3:0] a_r;
  logic [3:0] b_r;
  logic [3:0] hi;
  logic [1:0] cnt;
  logic [7:0] result_r;

  logic [2:0] alu_key_c;
  logic [3:0] alu_a_c;
  logic [3:0] alu_b_c;
  logic       busy_c;
  logic       done_c;

  logic       accept;
  logic       mul_last;

  assign accept   = (state == IDLE) && bus.start;
  assign mul_last = (state == MUL) && (cnt == 2'd3);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.op == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: state_nxt = DONE;
      MUL: begin
        if (cnt == 2'd3) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, purely from registered state and operand registers
  always_comb begin
    alu_key_c = KEY_NOP;
    alu_a_c   = 4'h0;
    alu_b_c   = 4'h0;
    busy_c    = (state != IDLE);
    done_c    = (state == DONE);
    case (state)
      EXEC: begin
        alu_key_c = op_r;
        alu_a_c   = a_r;
        alu_b_c   = b_r;
      end
      MUL: begin
        // Add is always issued; a clear multiplier bit simply adds zero.
        alu_key_c = KEY_ADD;
        alu_a_c   = hi;
        alu_b_c   = b_r[0] ? a_r : 4'h0;
      end
      default: begin
        alu_key_c = KEY_NOP;
        alu_a_c   = 4'h0;
        alu_b_c   = 4'h0;
      end
    endcase
  end

  // Operand, partial-product and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r     <= 3'b000;
      a_r      <= 4'h0;
      b_r      <= 4'h0;
      hi       <= 4'h0;
      cnt      <= 2'd0;
      result_r <= 8'h00;
    end else begin
      if (accept) begin
        op_r <= bus.op;
        a_r  <= bus.a;
        b_r  <= bus.b;
        hi   <= 4'h0;
        cnt  <= 2'd0;
      end

      if (state == EXEC) begin
        result_r <= bus.alu_out;
      end

      if (state == MUL) begin
        // {carry, sum, multiplier} shifts right by one: product accumulates in {hi, b_r}.
        hi  <= bus.alu_out[4:1];
        b_r <= {bus.alu_out[0], b_r[3:1]};
        cnt <= cnt + 2'd1;
      end

      if (mul_last) begin
        result_r <= {bus.alu_out[4:1], bus.alu_out[0], b_r[3:1]};
      end
    end
  end

  assign bus.alu_key = alu_key_c;
  assign bus.alu_a   = alu_a_c;
  assign bus.alu_b   = alu_b_c;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.result  = result_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU drives alu_out; a cycle-level model predicts every output.
// Directed cases pin literal results; a random phase exercises start/op/operands/reset freely.
module tb_alu_op_sequencer;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   cyc;

  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit ALU sitting behind the sequencer
  function automatic logic [7:0] alu_fn(input logic [2:0] k, input logic [3:0] x, input logic [3:0] y);
    logic [7:0] r;
    case (k)
      3'b010:  r = {x, y};
      3'b011:  r = {7'b0, &{x, y}};
      3'b100:  r = {4'h0, x ^ y};
      3'b101:  r = {x | y, x | y};
      3'b110:  r = {3'b000, {1'b0, x} + {1'b0, y}};
      3'b111:  r = {4'h0, x & y};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign bus.alu_out = alu_fn(bus.alu_key, bus.alu_a, bus.alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: cycles left in the current operation, and what it will produce
  bit         m_init;
  int         left;
  logic [7:0] m_res;
  logic [7:0] pend;
  logic [2:0] p_op;
  logic [3:0] p_a;
  logic [3:0] p_b;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_init = 1'b1;
      left   = 0;
      m_res  = 8'h00;
    end else if (m_init) begin
      if (left == 0) begin
        if (bus.start) begin
          p_op = bus.op;
          p_a  = bus.a;
          p_b  = bus.b;
          left = (bus.op == 3'b001) ? 5 : 2;
          pend = (bus.op == 3'b001) ? ({4'h0, bus.a} * {4'h0, bus.b}) : alu_fn(bus.op, bus.a, bus.b);
        end
      end else begin
        left--;
        if (left == 1) m_res = pend;
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] ek;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [7:0] prod;
    logic [3:0] mask;
    int         k;
    if (m_init) begin
      ek = 3'b000;
      ea = 4'h0;
      eb = 4'h0;
      if (left >= 2) begin
        if (p_op != 3'b001) begin
          ek = p_op;
          ea = p_a;
          eb = p_b;
        end else begin
          k    = 5 - left;
          mask = 4'((1 << k) - 1);
          prod = ({4'h0, p_a} * {4'h0, (p_b & mask)}) >> k;
          ek   = 3'b110;
          ea   = prod[3:0];
          eb   = p_b[k] ? p_a : 4'h0;
        end
      end
      chk("busy",    32'(bus.busy),    32'(left > 0));
      chk("done",    32'(bus.done),    32'(left == 1));
      chk("result",  32'(bus.result),  32'(m_res));
      chk("alu_key", 32'(bus.alu_key), 32'(ek));
      chk("alu_a",   32'(bus.alu_a),   32'(ea));
      chk("alu_b",   32'(bus.alu_b),   32'(eb));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done starting from cycle n; returns the cycle done was seen
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!bus.done && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [3:0] x,
                        input logic [3:0] y, input logic [7:0] exp, input int lat);
    int n;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    tick();
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a     = 4'($urandom);
    bus.b     = 4'($urandom);
    wait_done(1, n);
    chk({name, "_lat"}, 32'(n), 32'(lat));
    chk({name, "_res"}, 32'(bus.result), 32'(exp));
    tick();
  endtask

  initial begin
    int n;
    int dn[$];
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    m_init    = 1'b0;
    left      = 0;
    m_res     = 8'h00;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.op    = 3'b001;
    bus.a     = 4'h5;
    bus.b     = 4'h5;
    tick();
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (3) tick();
    chk("rst_result",  32'(bus.result),  32'h00);
    chk("rst_busy",    32'(bus.busy),    32'h0);
    chk("rst_done",    32'(bus.done),    32'h0);
    chk("rst_alu_key", 32'(bus.alu_key), 32'h0);
    chk("rst_alu_a",   32'(bus.alu_a),   32'h0);
    chk("rst_alu_b",   32'(bus.alu_b),   32'h0);

    run_op("add_9_8",  3'b110, 4'h9, 4'h8, 8'h11, 2);
    run_op("op5_a_5",  3'b101, 4'hA, 4'h5, 8'hFF, 2);
    run_op("op2_3_c",  3'b010, 4'h3, 4'hC, 8'h3C, 2);
    run_op("op3_f_f",  3'b011, 4'hF, 4'hF, 8'h01, 2);
    run_op("op0",      3'b000, 4'h7, 4'h3, 8'h00, 2);
    run_op("mul_d_b",  3'b001, 4'hD, 4'hB, 8'h8F, 5);
    run_op("mul_f_f",  3'b001, 4'hF, 4'hF, 8'hE1, 5);
    run_op("mul_0_9",  3'b001, 4'h0, 4'h9, 8'h00, 5);
    run_op("mul_1_f",  3'b001, 4'h1, 4'hF, 8'h0F, 5);

    // start pulsed mid-multiply is dropped
    bus.start = 1'b1;
    bus.op    = 3'b001;
    bus.a     = 4'h5;
    bus.b     = 4'h7;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.op    = 3'b110;
    bus.a     = 4'hF;
    bus.b     = 4'hF;
    tick();
    bus.start = 1'b0;
    wait_done(3, n);
    chk("mul_ign_lat", 32'(n), 32'd5);
    chk("mul_ign_res", 32'(bus.result), 32'h23);
    tick();
    tick();
    chk("mul_ign_idle", 32'(bus.busy), 32'h0);

    // start held high: back-to-back ALU ops, done every 3 cycles
    bus.start = 1'b1;
    bus.op    = 3'b010;
    bus.a     = 4'h1;
    bus.b     = 4'h2;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) dn.push_back(i);
    end
    bus.start = 1'b0;
    chk("b2b_count", 32'(dn.size()), 32'd4);
    for (int i = 1; i < dn.size(); i++) chk("b2b_gap", 32'(dn[i] - dn[i-1]), 32'd3);
    repeat (3) tick();

    // reset in the second MUL cycle aborts the multiply
    bus.start = 1'b1;
    bus.op    = 3'b001;
    bus.a     = 4'h9;
    bus.b     = 4'h9;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy",   32'(bus.busy),    32'h0);
    chk("abort_done",   32'(bus.done),    32'h0);
    chk("abort_result", 32'(bus.result),  32'h00);
    chk("abort_key",    32'(bus.alu_key), 32'h0);
    run_op("mul_7_6", 3'b001, 4'h7, 4'h6, 8'h2A, 5);

    // Random traffic, including requests while busy and occasional resets
    for (int i = 0; i < 800; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.op    = 3'($urandom);
      bus.a     = 4'($urandom);
      bus.b     = 4'($urandom);
      reset     = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
